// File: rtl/otter_pkg.sv
`default_nettype none
// ============================================================================
// otter_pkg
// Operand-select and ALU opcode encodings shared by the EX operand stage.
// Revision: 1.0
// ============================================================================
package otter_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] CONST_FOUR = 32'd4;

    typedef enum logic [1:0] {
        SRCA_RS1     = 2'b00,
        SRCA_IMM     = 2'b01,
        SRCA_NOT_RS1 = 2'b10,
        SRCA_ZERO    = 2'b11
    } srca_sel_e;

    typedef enum logic [2:0] {
        SRCB_RS2  = 3'b000,
        SRCB_IMM  = 3'b001,
        SRCB_PC   = 3'b010,
        SRCB_FOUR = 3'b011
    } srcb_sel_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_LUI  = 4'b1001,
        ALU_SRA  = 4'b1101
    } alu_fun_e;

    function automatic logic [XLEN-1:0] select_src_a(input logic [1:0]      sel,
                                                     input logic [XLEN-1:0] rs1,
                                                     input logic [XLEN-1:0] imm);
        case (srca_sel_e'(sel))
            SRCA_RS1:     return rs1;
            SRCA_IMM:     return imm;
            SRCA_NOT_RS1: return ~rs1;
            default:      return '0;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] select_src_b(input logic [2:0]      sel,
                                                     input logic [XLEN-1:0] rs2,
                                                     input logic [XLEN-1:0] imm,
                                                     input logic [XLEN-1:0] pc);
        case (srcb_sel_e'(sel))
            SRCB_RS2:  return rs2;
            SRCB_IMM:  return imm;
            SRCB_PC:   return pc;
            SRCB_FOUR: return CONST_FOUR;
            default:   return '0;
        endcase
    endfunction

    // A load-use hazard only matters when the register value is actually consumed.
    function automatic logic uses_rs1(input logic [1:0] sel);
        return (sel == SRCA_RS1) || (sel == SRCA_NOT_RS1);
    endfunction

    function automatic logic uses_rs2(input logic [2:0] sel);
        return (sel == SRCB_RS2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ex_operand_stage_fwd_unit.sv
`default_nettype none
// ============================================================================
// fwd_unit
// Resolves one source register: MEM result, then WB result, then register file.
// Revision: 1.0
// ============================================================================
module fwd_unit
    import otter_pkg::*;
(
    input  logic [4:0]      rs_addr_i,
    input  logic [XLEN-1:0] rf_data_i,
    input  logic            mem_wr_en_i,
    input  logic            mem_is_load_i,
    input  logic [4:0]      mem_rd_i,
    input  logic [XLEN-1:0] mem_result_i,
    input  logic            wb_wr_en_i,
    input  logic [4:0]      wb_rd_i,
    input  logic [XLEN-1:0] wb_result_i,
    output logic [XLEN-1:0] data_o
);

    logic w_rs_nonzero;
    logic w_mem_hit;
    logic w_wb_hit;

    // Load data is not available in MEM yet; that case is stalled, never forwarded.
    assign w_rs_nonzero = (rs_addr_i != 5'd0);
    assign w_mem_hit    = w_rs_nonzero & mem_wr_en_i & ~mem_is_load_i & (mem_rd_i == rs_addr_i);
    assign w_wb_hit     = w_rs_nonzero & wb_wr_en_i & (wb_rd_i == rs_addr_i);

    always_comb begin
        data_o = rf_data_i;
        if (w_mem_hit) begin
            data_o = mem_result_i;
        end else if (w_wb_hit) begin
            data_o = wb_result_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ex_operand_stage.sv
`default_nettype none
// ============================================================================
// ex_operand_stage
// Selects, forwards and registers ALU operands between decode and execute.
// Optional FORWARDING_EN enables MEM/WB bypass and load-use stall detection.
// Revision: 1.0
// ============================================================================
module ex_operand_stage
    import otter_pkg::*;
#(
    parameter int unsigned STALL_CNT_W = 16,
    parameter logic [3:0]  NOP_ALU_FUN = 4'b0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    output logic                   id_ready,
    input  logic [XLEN-1:0]        id_rs1_data,
    input  logic [XLEN-1:0]        id_rs2_data,
    input  logic [4:0]             id_rs1_addr,
    input  logic [4:0]             id_rs2_addr,
    input  logic [4:0]             id_rd_addr,
    input  logic [XLEN-1:0]        id_pc,
    input  logic [XLEN-1:0]        id_imm,
    input  logic [1:0]             id_srcA_sel,
    input  logic [2:0]             id_srcB_sel,
    input  logic [3:0]             id_alu_fun,
    input  logic                   flush,
    input  logic                   mem_wr_en,
    input  logic                   mem_is_load,
    input  logic [4:0]             mem_rd,
    input  logic [XLEN-1:0]        mem_result,
    input  logic                   wb_wr_en,
    input  logic [4:0]             wb_rd,
    input  logic [XLEN-1:0]        wb_result,
    input  logic                   ex_ready,
    output logic                   ex_valid,
    output logic [XLEN-1:0]        srcA,
    output logic [XLEN-1:0]        srcB,
    output logic [3:0]             alu_fun,
    output logic [4:0]             ex_rd_addr,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    logic [XLEN-1:0]        w_rs1_val;
    logic [XLEN-1:0]        w_rs2_val;
    logic                   w_hazard;
    logic                   w_ready;
    logic                   w_load;
    logic                   w_stall;

    logic                   ex_valid_q,   ex_valid_d;
    logic [XLEN-1:0]        srcA_q,       srcA_d;
    logic [XLEN-1:0]        srcB_q,       srcB_d;
    logic [3:0]             alu_fun_q,    alu_fun_d;
    logic [4:0]             ex_rd_addr_q, ex_rd_addr_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q,  stall_cnt_d;

`ifdef FORWARDING_EN
    fwd_unit u_fwd_rs1 (
        .rs_addr_i     (id_rs1_addr),
        .rf_data_i     (id_rs1_data),
        .mem_wr_en_i   (mem_wr_en),
        .mem_is_load_i (mem_is_load),
        .mem_rd_i      (mem_rd),
        .mem_result_i  (mem_result),
        .wb_wr_en_i    (wb_wr_en),
        .wb_rd_i       (wb_rd),
        .wb_result_i   (wb_result),
        .data_o        (w_rs1_val)
    );

    fwd_unit u_fwd_rs2 (
        .rs_addr_i     (id_rs2_addr),
        .rf_data_i     (id_rs2_data),
        .mem_wr_en_i   (mem_wr_en),
        .mem_is_load_i (mem_is_load),
        .mem_rd_i      (mem_rd),
        .mem_result_i  (mem_result),
        .wb_wr_en_i    (wb_wr_en),
        .wb_rd_i       (wb_rd),
        .wb_result_i   (wb_result),
        .data_o        (w_rs2_val)
    );

    assign w_hazard = mem_wr_en & mem_is_load & (mem_rd != 5'd0) &
                      (((mem_rd == id_rs1_addr) & uses_rs1(id_srcA_sel)) |
                       ((mem_rd == id_rs2_addr) & uses_rs2(id_srcB_sel)));
`else
    logic w_unused_fwd;

    assign w_rs1_val    = id_rs1_data;
    assign w_rs2_val    = id_rs2_data;
    assign w_hazard     = 1'b0;
    assign w_unused_fwd = ^{mem_wr_en, mem_is_load, mem_rd, mem_result,
                            wb_wr_en, wb_rd, wb_result, id_rs1_addr, id_rs2_addr};
`endif

    // Flush deliberately does not gate id_ready; it only suppresses the capture.
    assign w_ready = (~ex_valid_q | ex_ready) & ~w_hazard;
    assign w_load  = id_valid & w_ready & ~flush;
    assign w_stall = id_valid & ~w_ready & ~flush;

    always_comb begin
        ex_valid_d   = ex_valid_q;
        srcA_d       = srcA_q;
        srcB_d       = srcB_q;
        alu_fun_d    = alu_fun_q;
        ex_rd_addr_d = ex_rd_addr_q;
        stall_cnt_d  = stall_cnt_q;

        if (flush) begin
            ex_valid_d   = 1'b0;
            srcA_d       = '0;
            srcB_d       = '0;
            alu_fun_d    = NOP_ALU_FUN;
            ex_rd_addr_d = '0;
        end else if (w_load) begin
            ex_valid_d   = 1'b1;
            srcA_d       = select_src_a(id_srcA_sel, w_rs1_val, id_imm);
            srcB_d       = select_src_b(id_srcB_sel, w_rs2_val, id_imm, id_pc);
            alu_fun_d    = id_alu_fun;
            ex_rd_addr_d = id_rd_addr;
        end else if (ex_ready) begin
            ex_valid_d   = 1'b0;
        end

        if (w_stall && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid_q   <= 1'b0;
            srcA_q       <= '0;
            srcB_q       <= '0;
            alu_fun_q    <= NOP_ALU_FUN;
            ex_rd_addr_q <= '0;
            stall_cnt_q  <= '0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            srcA_q       <= srcA_d;
            srcB_q       <= srcB_d;
            alu_fun_q    <= alu_fun_d;
            ex_rd_addr_q <= ex_rd_addr_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign id_ready   = w_ready;
    assign ex_valid   = ex_valid_q;
    assign srcA       = srcA_q;
    assign srcB       = srcB_q;
    assign alu_fun    = alu_fun_q;
    assign ex_rd_addr = ex_rd_addr_q;
    assign stall_cnt  = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// tb_ex_operand_stage
// Directed scenarios plus random traffic against a cycle-level reference model.
// Revision: 1.0
// ============================================================================
module tb_ex_operand_stage;

    localparam int unsigned TB_CNT_W = 5;
    localparam logic [3:0]  TB_NOP   = 4'b1111;
    localparam logic [31:0] CNT_MAX  = (32'd1 << TB_CNT_W) - 32'd1;

    logic        clk = 1'b0;
    logic        rst_n, id_valid, flush, ex_ready;
    logic        mem_wr_en, mem_is_load, wb_wr_en;
    logic [31:0] id_rs1_data, id_rs2_data, id_pc, id_imm, mem_result, wb_result;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, mem_rd, wb_rd;
    logic [1:0]  id_srcA_sel;
    logic [2:0]  id_srcB_sel;
    logic [3:0]  id_alu_fun;

    logic                id_ready, ex_valid;
    logic [31:0]         srcA, srcB;
    logic [3:0]          alu_fun;
    logic [4:0]          ex_rd_addr;
    logic [TB_CNT_W-1:0] stall_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;

    bit          m_known = 1'b0;
    bit          m_valid;
    logic [31:0] m_a, m_b, m_stall;
    logic [3:0]  m_fun;
    logic [4:0]  m_rd;

    always #5 clk = ~clk;

    ex_operand_stage #(
        .STALL_CNT_W (TB_CNT_W),
        .NOP_ALU_FUN (TB_NOP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_rs1_data (id_rs1_data),
        .id_rs2_data (id_rs2_data),
        .id_rs1_addr (id_rs1_addr),
        .id_rs2_addr (id_rs2_addr),
        .id_rd_addr  (id_rd_addr),
        .id_pc       (id_pc),
        .id_imm      (id_imm),
        .id_srcA_sel (id_srcA_sel),
        .id_srcB_sel (id_srcB_sel),
        .id_alu_fun  (id_alu_fun),
        .flush       (flush),
        .mem_wr_en   (mem_wr_en),
        .mem_is_load (mem_is_load),
        .mem_rd      (mem_rd),
        .mem_result  (mem_result),
        .wb_wr_en    (wb_wr_en),
        .wb_rd       (wb_rd),
        .wb_result   (wb_result),
        .ex_ready    (ex_ready),
        .ex_valid    (ex_valid),
        .srcA        (srcA),
        .srcB        (srcB),
        .alu_fun     (alu_fun),
        .ex_rd_addr  (ex_rd_addr),
        .stall_cnt   (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Operand value as the architecture defines it: newest in-flight producer wins.
    function automatic logic [31:0] ref_reg(input logic [4:0] addr, input logic [31:0] rf);
        if (addr == 5'd0) return rf;
`ifdef FORWARDING_EN
        if (mem_wr_en && !mem_is_load && mem_rd == addr) return mem_result;
        if (wb_wr_en && wb_rd == addr) return wb_result;
`endif
        return rf;
    endfunction

    function automatic bit ref_hazard();
`ifdef FORWARDING_EN
        bit a_reads = (id_srcA_sel == 2'd0) || (id_srcA_sel == 2'd2);
        bit b_reads = (id_srcB_sel == 3'd0);
        return mem_wr_en && mem_is_load && (mem_rd != 5'd0) &&
               ((a_reads && mem_rd == id_rs1_addr) || (b_reads && mem_rd == id_rs2_addr));
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] ref_a();
        logic [31:0] r = ref_reg(id_rs1_addr, id_rs1_data);
        case (id_srcA_sel)
            2'd0:    return r;
            2'd1:    return id_imm;
            2'd2:    return ~r;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_b();
        logic [31:0] r = ref_reg(id_rs2_addr, id_rs2_data);
        case (id_srcB_sel)
            3'd0:    return r;
            3'd1:    return id_imm;
            3'd2:    return id_pc;
            3'd3:    return 32'd4;
            default: return 32'd0;
        endcase
    endfunction

    task automatic idle();
        rst_n = 1'b1; id_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1;
        mem_wr_en = 1'b0; mem_is_load = 1'b0; mem_rd = '0; mem_result = '0;
        wb_wr_en = 1'b0; wb_rd = '0; wb_result = '0;
        id_rs1_data = '0; id_rs2_data = '0; id_rs1_addr = '0; id_rs2_addr = '0;
        id_rd_addr = '0; id_pc = '0; id_imm = '0;
        id_srcA_sel = '0; id_srcB_sel = '0; id_alu_fun = '0;
    endtask

    task automatic rand_instr();
        id_rs1_data = $urandom; id_rs2_data = $urandom;
        id_pc = $urandom; id_imm = $urandom;
        id_rs1_addr = 5'($urandom_range(0, 7)); id_rs2_addr = 5'($urandom_range(0, 7));
        id_rd_addr = 5'($urandom); id_alu_fun = 4'($urandom);
        id_srcA_sel = 2'($urandom); id_srcB_sel = 3'($urandom);
    endtask

    task automatic rand_all();
        rand_instr();
        rst_n = ($urandom_range(0, 49) != 0);
        flush = ($urandom_range(0, 9) == 0);
        id_valid = ($urandom_range(0, 3) != 0);
        ex_ready = ($urandom_range(0, 2) != 0);
        mem_wr_en = $urandom_range(0, 1) == 1; mem_is_load = $urandom_range(0, 2) == 0;
        mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom;
        wb_wr_en = $urandom_range(0, 1) == 1;
        wb_rd = 5'($urandom_range(0, 7)); wb_result = $urandom;
    endtask

    // Inputs are stable from just after one edge until the next.
    task automatic cycle(input string tag);
        bit          rdy, ld;
        bit          n_valid;
        logic [31:0] n_a, n_b, n_stall;
        logic [3:0]  n_fun;
        logic [4:0]  n_rd;
        #1;
        rdy = (!m_valid || ex_ready) && !ref_hazard();
        if (m_known) check({tag, ":id_ready"}, {31'd0, id_ready}, {31'd0, rdy});
        ld = id_valid && rdy && !flush;
        n_valid = m_valid; n_a = m_a; n_b = m_b; n_fun = m_fun; n_rd = m_rd; n_stall = m_stall;
        if (!rst_n) begin
            n_valid = 1'b0; n_a = '0; n_b = '0; n_fun = TB_NOP; n_rd = '0; n_stall = '0;
        end else begin
            if (flush) begin
                n_valid = 1'b0; n_a = '0; n_b = '0; n_fun = TB_NOP; n_rd = '0;
            end else if (ld) begin
                n_valid = 1'b1; n_a = ref_a(); n_b = ref_b(); n_fun = id_alu_fun; n_rd = id_rd_addr;
            end else if (ex_ready) begin
                n_valid = 1'b0;
            end
            if (id_valid && !rdy && !flush && m_stall < CNT_MAX) n_stall = m_stall + 1;
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_a = n_a; m_b = n_b; m_fun = n_fun; m_rd = n_rd; m_stall = n_stall;
        if (!rst_n) m_known = 1'b1;
        if (m_known) begin
            check({tag, ":ex_valid"},   {31'd0, ex_valid},   {31'd0, m_valid});
            check({tag, ":srcA"},       srcA,                m_a);
            check({tag, ":srcB"},       srcB,                m_b);
            check({tag, ":alu_fun"},    {28'd0, alu_fun},    {28'd0, m_fun});
            check({tag, ":ex_rd_addr"}, {27'd0, ex_rd_addr}, {27'd0, m_rd});
            check({tag, ":stall_cnt"},  {27'd0, stall_cnt},  m_stall);
        end
    endtask

    initial begin
        idle();
        rst_n = 1'b0; id_valid = 1'b1; flush = 1'b1;
        cycle("reset");
        idle();
        rst_n = 1'b0;
        cycle("reset2");
        check("reset_fun_const", {28'd0, alu_fun}, {28'd0, TB_NOP});

        idle();
        id_valid = 1'b1; id_rs1_data = 32'd5; id_rs2_data = 32'd7;
        id_rs1_addr = 5'd1; id_rs2_addr = 5'd2; id_rd_addr = 5'd9;
        cycle("basic");
        check("basic_srcA_const", srcA, 32'd5);
        check("basic_srcB_const", srcB, 32'd7);

        idle();
        id_valid = 1'b1; id_rs1_addr = 5'd3; id_rs1_data = 32'h11;
        mem_wr_en = 1'b1; mem_rd = 5'd3; mem_result = 32'hAA;
        wb_wr_en = 1'b1; wb_rd = 5'd3; wb_result = 32'hBB;
        cycle("fwd_mem");
        mem_rd = 5'd0;
        cycle("fwd_wb");
        id_rs1_addr = 5'd0; wb_rd = 5'd0;
        cycle("fwd_x0");

        idle();
        id_valid = 1'b1; id_rs2_addr = 5'd4; id_rs2_data = 32'h44;
        mem_wr_en = 1'b1; mem_is_load = 1'b1; mem_rd = 5'd4;
        cycle("load_use");
        mem_wr_en = 1'b0;
        cycle("load_use_go");

        idle();
        rst_n = 1'b0;
        cycle("reset3");
        idle();
        id_valid = 1'b1; rand_instr();
        cycle("pre_hold");
        ex_ready = 1'b0;
        repeat (3) begin
            rand_instr();
            cycle("hold");
        end
        check("hold_stall3", {27'd0, stall_cnt}, 32'd3);

        idle();
        id_valid = 1'b1; flush = 1'b1; rand_instr();
        cycle("flush");

        idle();
        id_valid = 1'b1; rand_instr();
        cycle("pre_sat");
        ex_ready = 1'b0;
        repeat (40) begin
            rand_instr();
            cycle("saturate");
        end
        check("sat_max", {27'd0, stall_cnt}, CNT_MAX);

        rst_n = 1'b0; flush = 1'b1;
        cycle("reset_held");

        for (int i = 0; i < 600; i++) begin
            rand_all();
            cycle("random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
`default_nettype wire
